// File: rtl/uart_tx_fifo_pkg.sv
// uart_tx_fifo_pkg
//   Shared definitions for the UART transmit FIFO slice: the UART data width
//   and the issue-FSM state encoding used by uart_tx_fifo.
package uart_tx_fifo_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_ACK  = 2'd1,
        S_WAIT_DONE = 2'd2
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// uart_tx_fifo_mem
//   DEPTH x UART_DATA_W register array: synchronous write, asynchronous read.
//   Ports:
//     clk    in   write clock (posedge)
//     we     in   write enable
//     waddr  in   write address
//     wdata  in   write byte
//     raddr  in   read address
//     rdata  out  byte stored at raddr (combinational)
module uart_tx_fifo_mem
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [UART_DATA_W-1:0] wdata,
    input  logic [AW-1:0]          raddr,
    output logic [UART_DATA_W-1:0] rdata
);

    logic [UART_DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Byte FIFO plus issue FSM feeding a UART transmitter one byte at a time.
//   Each issued byte produces a one-cycle tx_en strobe with tx_data valid in
//   the same cycle; the next issue waits for tx_busy to rise and fall again,
//   or for ACK_TIMEOUT cycles without a busy rise.
//   Optional feature: define UART_TX_FIFO_OVF_EN for a sticky overflow flag
//   that sets on any dropped write; otherwise overflow is tied low.
//   Ports:
//     clk      in   system clock (posedge)
//     rst      in   asynchronous active-high reset
//     wr_en    in   push wr_data this cycle
//     wr_data  in   byte to enqueue
//     full     out  FIFO holds DEPTH bytes (registered)
//     empty    out  FIFO holds 0 bytes (registered)
//     count    out  occupancy 0..DEPTH (registered)
//     tx_busy  in   transmitter shifting a frame
//     tx_data  out  last issued byte
//     tx_en    out  one-cycle issue strobe
//     overflow out  sticky drop flag
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter  int DEPTH       = 16,
    parameter  int ACK_TIMEOUT = 64,
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [UART_DATA_W-1:0] wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [AW:0]            count,
    input  logic                   tx_busy,
    output logic [UART_DATA_W-1:0] tx_data,
    output logic                   tx_en,
    output logic                   overflow
);

    localparam int TW = $clog2(ACK_TIMEOUT) + 1;

    tx_state_e              state, state_n;
    logic [TW-1:0]          timer, timer_n;
    logic                   tx_en_n;
    logic [UART_DATA_W-1:0] tx_data_n;
    logic [UART_DATA_W-1:0] rd_byte;
    logic [AW:0]            wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic                   push, pop;

    // Full is judged on the registered flag, so a same-cycle pop never
    // rescues a write into a full FIFO.
    assign push     = wr_en && !full;
    assign wr_ptr_n = push ? wr_ptr + (AW+1)'(1) : wr_ptr;
    assign rd_ptr_n = pop  ? rd_ptr + (AW+1)'(1) : rd_ptr;

    uart_tx_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_byte)
    );

    // Flags are derived from the next-state pointers so they are registered
    // yet consistent with the pointers in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr_n;
            rd_ptr <= rd_ptr_n;
            count  <= wr_ptr_n - rd_ptr_n;
            full   <= (wr_ptr_n[AW] != rd_ptr_n[AW]) &&
                      (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);
            empty  <= (wr_ptr_n == rd_ptr_n);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            timer   <= '0;
            tx_en   <= 1'b0;
            tx_data <= '0;
        end else begin
            state   <= state_n;
            timer   <= timer_n;
            tx_en   <= tx_en_n;
            tx_data <= tx_data_n;
        end
    end

    // WAIT_ACK lasts at most ACK_TIMEOUT cycles: timer counts 0..ACK_TIMEOUT-1.
    always_comb begin
        state_n   = state;
        timer_n   = timer;
        tx_en_n   = 1'b0;
        tx_data_n = tx_data;
        pop       = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!empty && !tx_busy) begin
                    pop       = 1'b1;
                    tx_en_n   = 1'b1;
                    tx_data_n = rd_byte;
                    timer_n   = '0;
                    state_n   = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (tx_busy) begin
                    state_n = S_WAIT_DONE;
                end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
                    state_n = S_IDLE;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

`ifdef UART_TX_FIFO_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end
    end
`else
    assign overflow = 1'b0;
`endif

endmodule
